// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: state encoding, frame indices, 25 MHz timing defaults and odd parity.
package ps2_pkg;

  localparam int DEF_INHIBIT_CYCLES = 2500;    // 100 us at 25 MHz
  localparam int DEF_TIMEOUT_CYCLES = 375000;  // 15 ms at 25 MHz
  localparam int DEF_FILTER_LEN     = 4;
  localparam int DEF_RETRIES        = 2;

  localparam int FRAME_W  = 9;   // {parity, data}
  localparam int STOP_IDX = 9;
  localparam int ACK_IDX  = 10;

  typedef logic [2:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE    = 3'd0;
  localparam ps2_state_t ST_INHIBIT = 3'd1;
  localparam ps2_state_t ST_START   = 3'd2;
  localparam ps2_state_t ST_SHIFT   = 3'd3;
  localparam ps2_state_t ST_ACK     = 3'd4;
  localparam ps2_state_t ST_WAITREL = 3'd5;
  localparam ps2_state_t ST_FAIL    = 3'd6;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pad conditioner: 2-FF synchroniser, FILTER_LEN-sample stable filter, falling-edge pulse.
// Pad edge to fall pulse is FILTER_LEN+2 cycles. FILTER_LEN must be >= 2.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic pad,
  output logic level,
  output logic fall
);

  logic [1:0]            sync;
  logic [FILTER_LEN-2:0] hist;
  logic [FILTER_LEN-1:0] win;

  assign win = {hist, sync[1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      // idle PS/2 lines float high, so start from a released view
      sync  <= '1;
      hist  <= '1;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], pad};
      hist <= win[FILTER_LEN-2:0];
      fall <= 1'b0;
      if (&win) begin
        level <= 1'b1;
      end else if (~|win) begin
        level <= 1'b0;
        fall  <= level;
      end
    end
  end

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter with open-drain "pull low when 1" outputs.
// Optional feature: define PS2_TX_RETRY_EN to retry a failed frame up to RETRIES times.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int RETRIES        = DEF_RETRIES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_send,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps_clock_i,
  input  logic       ps_data_i,
  output logic       ps_clock_oe,
  output logic       ps_data_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ps2_state_t         state;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] shift;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         idx;
  logic               clk_lvl, clk_fall, dat_lvl, dat_fall_unused;
  logic               timeout, can_retry;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clock(clock), .reset(reset), .pad(ps_clock_i), .level(clk_lvl), .fall(clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clock(clock), .reset(reset), .pad(ps_data_i), .level(dat_lvl), .fall(dat_fall_unused)
  );

  assign busy    = (state != ST_IDLE);
  assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_TX_RETRY_EN
  localparam int ATT_W = $clog2(RETRIES + 2);
  logic [ATT_W-1:0] attempt;

  always_ff @(posedge clock) begin
    if (reset || state == ST_IDLE) attempt <= '0;
    else if (state == ST_FAIL && can_retry) attempt <= attempt + ATT_W'(1);
  end

  assign can_retry = (attempt != ATT_W'(RETRIES));
`else
  localparam int RETRIES_UNUSED = RETRIES;
  assign can_retry = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      frame       <= '0;
      shift       <= '0;
      cnt         <= '0;
      idx         <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      ps_clock_oe <= 1'b0;
      ps_data_oe  <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: if (tx_send) begin
          frame       <= {odd_parity(tx_data), tx_data};
          ps_clock_oe <= 1'b1;
          cnt         <= '0;
          state       <= ST_INHIBIT;
        end
        ST_INHIBIT: begin
          if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
            ps_data_oe <= 1'b1;
            state      <= ST_START;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_START: begin
          ps_clock_oe <= 1'b0;
          cnt         <= '0;
          idx         <= '0;
          shift       <= frame;
          state       <= ST_SHIFT;
        end
        ST_SHIFT: begin
          cnt <= cnt + CNT_W'(1);
          if (timeout) begin
            ps_data_oe <= 1'b0;
            state      <= ST_FAIL;
          end else if (clk_fall) begin
            if (idx == 4'(STOP_IDX)) begin
              ps_data_oe <= 1'b0;
              idx        <= 4'(ACK_IDX);
              state      <= ST_ACK;
            end else begin
              ps_data_oe <= ~shift[0];
              shift      <= shift >> 1;
              idx        <= idx + 4'd1;
            end
          end
        end
        ST_ACK: begin
          cnt <= cnt + CNT_W'(1);
          if (timeout) state <= ST_FAIL;
          else if (clk_fall) state <= dat_lvl ? ST_FAIL : ST_WAITREL;
        end
        ST_WAITREL: begin
          cnt <= cnt + CNT_W'(1);
          if (timeout) begin
            state <= ST_FAIL;
          end else if (clk_lvl && dat_lvl) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_FAIL: begin
          ps_data_oe <= 1'b0;
          if (can_retry) begin
            // same frame again; busy stays high across the retry
            ps_clock_oe <= 1'b1;
            cnt         <= '0;
            state       <= ST_INHIBIT;
          end else begin
            ps_clock_oe <= 1'b0;
            error       <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: behavioural open-drain PS/2 device with directed and random frames.
module tb_ps2_tx;

  localparam int INH = 50;
  localparam int TMO = 5000;
  localparam int FL  = 4;
  localparam int RET = 2;
`ifdef PS2_TX_RETRY_EN
  localparam int R_EFF = RET;
`else
  localparam int R_EFF = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_send = 1'b0;
  logic       busy, done, error;
  logic       ps_clock_i, ps_data_i, ps_clock_oe, ps_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;

  int tests = 0, fails = 0, done_cnt = 0, err_cnt = 0, half = 20;

  // open-drain wired lines: either side can pull low
  assign ps_clock_i = dev_clk & ~ps_clock_oe;
  assign ps_data_i  = dev_dat & ~ps_data_oe;

  ps2_tx #(
    .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FL), .RETRIES(RET)
  ) dut (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_send(tx_send),
    .busy(busy), .done(done), .error(error),
    .ps_clock_i(ps_clock_i), .ps_data_i(ps_data_i),
    .ps_clock_oe(ps_clock_oe), .ps_data_oe(ps_data_oe)
  );

  always #20 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) err_cnt++;
  endtask

  // bits as the device sees them on its rising edges: data LSB first, odd parity, stop
  function automatic logic [9:0] exp_bits(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d};
  endfunction

  task automatic send(input logic [7:0] d);
    tx_data = d;
    tx_send = 1'b1;
    tick();
    tx_send = 1'b0;
  endtask

  task automatic dev_xfer(input bit ack, input int abort_fall,
                          output logic [9:0] bits, output bit ok, output bit stable);
    int   n;
    logic hold;
    bits = '0; ok = 1'b0; stable = 1'b1; n = 0;
    while (!(ps_data_oe === 1'b1 && ps_clock_oe === 1'b0) && n < INH + 400) begin
      tick(); n++;
    end
    if (n >= INH + 400) return;
    ok = 1'b1;
    repeat (10) tick();
    for (int i = 1; i <= 11; i++) begin
      dev_clk = 1'b0;
      repeat (half) tick();
      if (i == abort_fall) begin
        reset = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_oe", 32'({ps_clock_oe, ps_data_oe}), 32'd0);
        check("abort_pulses", 32'({done, error}), 32'd0);
        reset   = 1'b0;
        dev_clk = 1'b1;
        return;
      end
      if (i <= 10) bits = {ps_data_i, bits[9:1]};
      hold    = ps_data_oe;
      dev_clk = 1'b1;
      if (i == 10 && ack) dev_dat = 1'b0;
      if (i == 11) dev_dat = 1'b1;
      repeat (half) begin
        tick();
        if (ps_data_oe !== hold) stable = 1'b0;
      end
    end
  endtask

  // device NACKs the first `nacks` attempts, then ACKs
  task automatic run_frame(input logic [7:0] d, input int nacks, input bit inject);
    int         d0, e0, att, n;
    logic [9:0] bits;
    bit         ok, st, succeed;
    d0 = done_cnt; e0 = err_cnt;
    succeed = (nacks <= R_EFF);
    send(d);
    if (inject) begin
      repeat (5) tick();
      tx_data = ~d;
      tx_send = 1'b1;
      tick();
      tx_send = 1'b0;
    end
    att = succeed ? nacks + 1 : R_EFF + 1;
    for (int a = 0; a < att; a++) begin
      dev_xfer(a >= nacks, 0, bits, ok, st);
      check("start_seen", 32'(ok), 32'd1);
      check("frame_bits", 32'(bits), 32'(exp_bits(d)));
      check("oe_stable_clk_high", 32'(st), 32'd1);
    end
    n = 0;
    while (busy === 1'b1 && n < 2000) begin tick(); n++; end
    check("idle_reached", 32'(busy), 32'd0);
    check("done_pulses", 32'(done_cnt - d0), 32'(succeed));
    check("error_pulses", 32'(err_cnt - e0), 32'(!succeed));
    check("oe_released", 32'({ps_clock_oe, ps_data_oe}), 32'd0);
    if (inject) begin
      n = 0;
      repeat (4 * INH) begin
        tick();
        if (ps_clock_oe !== 1'b0) n++;
      end
      check("dropped_send_no_frame", 32'(n), 32'd0);
    end
  endtask

  initial begin
    int         d0, e0, n, m;
    logic [9:0] bits;
    bit         ok, st;

    // reset state
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({done, error}), 32'd0);
    check("rst_clock_oe", 32'(ps_clock_oe), 32'd0);
    check("rst_data_oe", 32'(ps_data_oe), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // directed bytes, then random bytes at random device clock rates
    run_frame(8'hED, 0, 1'b0);
    run_frame(8'h00, 0, 1'b0);
    run_frame(8'h01, 0, 1'b0);
    run_frame(8'hFF, 0, 1'b0);
    repeat (4) begin
      half = int'($urandom_range(15, 25));
      run_frame(8'($urandom), 0, 1'b0);
    end
    half = 20;

    // NACK on every attempt ends in error
    run_frame(8'h3C, R_EFF + 1, 1'b0);

    // device never clocks
    d0 = done_cnt; e0 = err_cnt;
    send(8'h55);
    n = 0;
    while (ps_clock_oe === 1'b1 && n < INH + 20) begin n++; tick(); end
    check("inhibit_len", 32'(n), 32'(INH + 1));
    check("start_bit_held", 32'(ps_data_oe), 32'd1);
    m = 0;
    while (error !== 1'b1 && ps_clock_oe !== 1'b1 && m < TMO + 50) begin tick(); m++; end
    check("timeout_window", 32'(m >= TMO - 1 && m <= TMO + 1), 32'd1);
    n = 0;
    while (err_cnt == e0 && n < (R_EFF + 1) * (TMO + INH + 50)) begin tick(); n++; end
    tick();
    check("timeout_error", 32'(err_cnt - e0), 32'd1);
    check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
    check("timeout_idle", 32'({busy, ps_clock_oe, ps_data_oe}), 32'd0);

    // reset after 4th fall aborts silently; next frame still works
    d0 = done_cnt; e0 = err_cnt;
    send(8'hA0);
    dev_xfer(1'b1, 4, bits, ok, st);
    check("abort_start_seen", 32'(ok), 32'd1);
    repeat (20) tick();
    check("abort_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    run_frame(8'hF4, 0, 1'b0);

    // tx_send while busy is dropped
    run_frame(8'h96, 0, 1'b1);

    // two NACKs then ACK: done with retries, error without
    run_frame(8'hA5, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
